// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
//
// Bundles the UART receiver side and the host read side of uart_rx_fifo.
//
//   rx_data / rx_parity_error / rx_stop_error   frame payload from the receiver
//   rx_valid                                    frame-complete level (async)
//   rd_en                                       host pop request
//   overrun_clr                                 host clear of the sticky overrun
//   rd_data / rd_parity_err / rd_stop_err       head entry (first-word-fall-through)
//   empty / full / count                        occupancy status
//   overrun                                     sticky lost-frame flag
//   err_drop_cnt                                saturating count of discarded frames
//
// master: the receiver/host side driving the FIFO.  slave: the FIFO itself.
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if #(
    parameter int unsigned ADDR_W = 4
);
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            rx_parity_error;
    logic            rx_stop_error;
    logic            rd_en;
    logic            overrun_clr;
    logic [7:0]      rd_data;
    logic            rd_parity_err;
    logic            rd_stop_err;
    logic            empty;
    logic            full;
    logic [ADDR_W:0] count;
    logic            overrun;
    logic [7:0]      err_drop_cnt;

    modport master (
        output rx_data,
        output rx_valid,
        output rx_parity_error,
        output rx_stop_error,
        output rd_en,
        output overrun_clr,
        input  rd_data,
        input  rd_parity_err,
        input  rd_stop_err,
        input  empty,
        input  full,
        input  count,
        input  overrun,
        input  err_drop_cnt
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  rx_parity_error,
        input  rx_stop_error,
        input  rd_en,
        input  overrun_clr,
        output rd_data,
        output rd_parity_err,
        output rd_stop_err,
        output empty,
        output full,
        output count,
        output overrun,
        output err_drop_cnt
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive buffer downstream of a UART receiver. Each completed frame (8 data
// bits plus parity/stop error flags) is captured into a DEPTH-entry FIFO on
// the system clock. rx_valid is asynchronous to clk, so it is synchronized
// and rising-edge detected; the frame payload is sampled from the live rx_*
// inputs in the capture cycle (the receiver holds it stable long enough).
// The host drains the FIFO through a first-word-fall-through read port.
//
// Ports:
//   clk    system clock, all state on the rising edge
//   reset  asynchronous, active-high reset
//   bus    uart_rx_fifo_if.slave (receiver inputs, host read port, status)
//
// Parameters:
//   DEPTH         number of entries, power of two, 2..256
//   ADDR_W        log2(DEPTH)
//   DROP_ERRORED  1: frames with a parity or stop error are discarded and
//                 counted in err_drop_cnt instead of being stored
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned ADDR_W       = 4,
    parameter bit          DROP_ERRORED = 1'b0
) (
    input logic           clk,
    input logic           reset,
    uart_rx_fifo_if.slave bus
);

    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);

    // Synchronizer chain plus history flop
    logic s1_q, s2_q, s3_q;
    logic cap;

    // Write side
    logic       frame_err;
    logic       wr;
    logic       drop;
    logic [9:0] wr_entry;

    // FIFO state
    logic [9:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wp_q, wp_d;
    logic [ADDR_W-1:0] rp_q, rp_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        err_drop_cnt_q, err_drop_cnt_d;

    logic empty;
    logic full;
    logic pop;
    logic push;
    logic overrun_set;
    logic [9:0] head;

    // -----------------------------------------------------------------------
    // rx_valid synchronizer. All flops preset to 1 so a rx_valid that is
    // already high when reset releases is not mistaken for a new frame.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= bus.rx_valid;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign cap = s2_q & ~s3_q;

    // -----------------------------------------------------------------------
    // Write qualification and occupancy decode
    // -----------------------------------------------------------------------
    always_comb begin
        frame_err = bus.rx_parity_error | bus.rx_stop_error;
        wr_entry  = {bus.rx_stop_error, bus.rx_parity_error, bus.rx_data};
        drop      = cap & DROP_ERRORED & frame_err;
        wr        = cap & ~(DROP_ERRORED & frame_err);

        empty       = (count_q == '0);
        full        = (count_q == DepthCnt);
        pop         = bus.rd_en & ~empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push        = wr & (~full | pop);
        overrun_set = wr & full & ~pop;
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        wp_d           = wp_q;
        rp_d           = rp_q;
        count_d        = count_q;
        overrun_d      = overrun_q;
        err_drop_cnt_d = err_drop_cnt_q;

        if (push) begin
            wp_d = wp_q + ADDR_W'(1);
        end
        if (pop) begin
            rp_d = rp_q + ADDR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        // Set has priority over clear so a simultaneous loss is never hidden.
        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (bus.overrun_clr) begin
            overrun_d = 1'b0;
        end

        if (drop && (err_drop_cnt_q != 8'hFF)) begin
            err_drop_cnt_d = err_drop_cnt_q + 8'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Control state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q           <= '0;
            rp_q           <= '0;
            count_q        <= '0;
            overrun_q      <= 1'b0;
            err_drop_cnt_q <= 8'd0;
        end else begin
            wp_q           <= wp_d;
            rp_q           <= rp_d;
            count_q        <= count_d;
            overrun_q      <= overrun_d;
            err_drop_cnt_q <= err_drop_cnt_d;
        end
    end

    // Storage is intentionally not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= wr_entry;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: head entry falls through combinationally from storage; status
    // is decoded from registered state only, so rd_en never reaches an output.
    // -----------------------------------------------------------------------
    assign head = mem_q[rp_q];

    assign bus.rd_data       = head[7:0];
    assign bus.rd_parity_err = head[8];
    assign bus.rd_stop_err   = head[9];
    assign bus.empty         = empty;
    assign bus.full          = full;
    assign bus.count         = count_q;
    assign bus.overrun       = overrun_q;
    assign bus.err_drop_cnt  = err_drop_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Bench for uart_rx_fifo. dut0 keeps errored frames, dut1 discards them.
// Inputs change 1 time unit after a rising edge; outputs are read at the
// same point, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int unsigned Depth = 16;
    localparam int unsigned AddrW = 4;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.ADDR_W(AddrW)) if0 ();
    uart_rx_fifo_if #(.ADDR_W(AddrW)) if1 ();

    uart_rx_fifo #(
        .DEPTH        (Depth),
        .ADDR_W       (AddrW),
        .DROP_ERRORED (1'b0)
    ) dut0 (
        .clk   (clk),
        .reset (rst0),
        .bus   (if0)
    );

    uart_rx_fifo #(
        .DEPTH        (Depth),
        .ADDR_W       (AddrW),
        .DROP_ERRORED (1'b1)
    ) dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (if1)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: one queue of {stop, parity, data} per DUT
    logic [9:0] mq0[$];
    logic [9:0] mq1[$];
    int         mov[2];
    int         mdrop[2];

    typedef struct {
        bit         is_read;
        logic [7:0] data;
        logic       pe;
        logic       se;
        int         exp_count;
        logic [7:0] exp_head;
        int         exp_drop;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_rx(input int sel, input logic v, input logic [7:0] d,
                          input logic pe, input logic se);
        if (sel == 0) begin
            if0.rx_valid = v; if0.rx_data = d;
            if0.rx_parity_error = pe; if0.rx_stop_error = se;
        end else begin
            if1.rx_valid = v; if1.rx_data = d;
            if1.rx_parity_error = pe; if1.rx_stop_error = se;
        end
    endtask

    task automatic set_rd(input int sel, input logic v);
        if (sel == 0) if0.rd_en = v; else if1.rd_en = v;
    endtask

    task automatic set_clr(input int sel, input logic v);
        if (sel == 0) if0.overrun_clr = v; else if1.overrun_clr = v;
    endtask

    task automatic get_out(input int sel, output logic [7:0] d, output logic pe,
                           output logic se, output logic emp, output logic ful,
                           output logic ovr, output int cnt, output int dc);
        if (sel == 0) begin
            d = if0.rd_data; pe = if0.rd_parity_err; se = if0.rd_stop_err;
            emp = if0.empty; ful = if0.full; ovr = if0.overrun;
            cnt = int'(if0.count); dc = int'(if0.err_drop_cnt);
        end else begin
            d = if1.rd_data; pe = if1.rd_parity_err; se = if1.rd_stop_err;
            emp = if1.empty; ful = if1.full; ovr = if1.overrun;
            cnt = int'(if1.count); dc = int'(if1.err_drop_cnt);
        end
    endtask

    // One whole frame: valid high 4 cycles (payload stable), then low 3 cycles.
    task automatic send_frame(input int sel, input logic [7:0] d,
                              input logic pe, input logic se);
        set_rx(sel, 1'b1, d, pe, se);
        repeat (4) tick();
        set_rx(sel, 1'b0, d, pe, se);
        repeat (3) tick();
    endtask

    task automatic read1(input int sel);
        set_rd(sel, 1'b1);
        tick();
        set_rd(sel, 1'b0);
    endtask

    task automatic check_head(input int sel, input string tag, input logic [7:0] exp_d,
                              input int exp_cnt);
        logic [7:0] d; logic pe, se, emp, ful, ovr; int cnt, dc;
        get_out(sel, d, pe, se, emp, ful, ovr, cnt, dc);
        check($sformatf("%s.rd_data", tag), int'(d), int'(exp_d));
        check($sformatf("%s.count", tag), cnt, exp_cnt);
    endtask

    // Frame-level model: a frame is dropped (drop mode), stored, or lost.
    task automatic model_frame(input int sel, input logic [7:0] d,
                               input logic pe, input logic se);
        int sz;
        sz = (sel == 0) ? mq0.size() : mq1.size();
        if (sel == 1 && (pe || se)) begin
            if (mdrop[1] < 255) mdrop[1]++;
        end else if (sz < Depth) begin
            if (sel == 0) mq0.push_back({se, pe, d}); else mq1.push_back({se, pe, d});
        end else begin
            mov[sel] = 1;
        end
    endtask

    task automatic model_pop(input int sel);
        if (sel == 0) begin
            if (mq0.size() > 0) void'(mq0.pop_front());
        end else begin
            if (mq1.size() > 0) void'(mq1.pop_front());
        end
    endtask

    task automatic check_model(input int sel, input string tag);
        logic [7:0] d; logic pe, se, emp, ful, ovr; int cnt, dc, sz;
        logic [9:0] h;
        get_out(sel, d, pe, se, emp, ful, ovr, cnt, dc);
        sz = (sel == 0) ? mq0.size() : mq1.size();
        h = '0;
        if (sz > 0) h = (sel == 0) ? mq0[0] : mq1[0];
        check($sformatf("%s.count", tag), cnt, sz);
        check($sformatf("%s.empty", tag), int'(emp), int'(sz == 0));
        check($sformatf("%s.full", tag), int'(ful), int'(sz == Depth));
        check($sformatf("%s.overrun", tag), int'(ovr), mov[sel]);
        check($sformatf("%s.drop_cnt", tag), dc, mdrop[sel]);
        if (sz > 0) begin
            check($sformatf("%s.head", tag), int'({se, pe, d}), int'(h));
        end
    endtask

    initial begin
        logic [7:0] d; logic pe, se, emp, ful, ovr; int cnt, dc;

        vecs[0] = '{1'b0, 8'h11, 1'b1, 1'b0, 0, 8'h00, 1};
        vecs[1] = '{1'b0, 8'h22, 1'b0, 1'b0, 1, 8'h22, 1};
        vecs[2] = '{1'b0, 8'h33, 1'b0, 1'b1, 1, 8'h22, 2};
        vecs[3] = '{1'b1, 8'h00, 1'b0, 1'b0, 0, 8'h00, 2};
        vecs[4] = '{1'b0, 8'h44, 1'b1, 1'b1, 0, 8'h00, 3};

        set_rx(0, 1'b1, 8'h00, 1'b0, 1'b0);  // rx_valid already high at reset
        set_rx(1, 1'b0, 8'h00, 1'b0, 1'b0);
        set_rd(0, 1'b0); set_rd(1, 1'b0);
        set_clr(0, 1'b0); set_clr(1, 1'b0);
        rst0 = 1'b1; rst1 = 1'b1;
        repeat (2) tick();
        rst0 = 1'b0; rst1 = 1'b0;
        repeat (5) tick();

        // ---- Reset release with rx_valid high: no capture ----
        get_out(0, d, pe, se, emp, ful, ovr, cnt, dc);
        check("reset.empty", int'(emp), 1);
        check("reset.full", int'(ful), 0);
        check("reset.count", cnt, 0);
        check("reset.overrun", int'(ovr), 0);
        check("reset.drop_cnt", dc, 0);

        // ---- First frame 0xA5: empty falls exactly on the 3rd edge ----
        set_rx(0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) tick();
        set_rx(0, 1'b1, 8'hA5, 1'b0, 1'b0);
        tick();  // E0
        tick();  // E1
        get_out(0, d, pe, se, emp, ful, ovr, cnt, dc);
        check("lat.empty_e1", int'(emp), 1);
        tick();  // E2
        get_out(0, d, pe, se, emp, ful, ovr, cnt, dc);
        check("lat.empty_e2", int'(emp), 0);
        check("lat.rd_data", int'(d), 8'hA5);
        check("lat.perr", int'(pe), 0);
        check("lat.serr", int'(se), 0);
        check("lat.count", cnt, 1);
        tick();
        set_rx(0, 1'b0, 8'hA5, 1'b0, 1'b0);
        repeat (3) tick();
        read1(0);
        get_out(0, d, pe, se, emp, ful, ovr, cnt, dc);
        check("lat.empty_after_read", int'(emp), 1);

        // ---- Fill to full, then overrun ----
        for (int i = 0; i < 16; i++) send_frame(0, 8'(i), 1'b0, 1'b0);
        get_out(0, d, pe, se, emp, ful, ovr, cnt, dc);
        check("fill.full", int'(ful), 1);
        check("fill.count", cnt, 16);
        check("fill.overrun", int'(ovr), 0);
        send_frame(0, 8'hFF, 1'b0, 1'b0);
        get_out(0, d, pe, se, emp, ful, ovr, cnt, dc);
        check("ovr.overrun", int'(ovr), 1);
        check("ovr.count", cnt, 16);
        check("ovr.head", int'(d), 8'h00);

        // ---- overrun_clr in the same cycle as a new overrun ----
        set_rx(0, 1'b1, 8'hEE, 1'b0, 1'b0);
        tick();  // E0
        tick();  // E1: cap high this cycle
        set_clr(0, 1'b1);
        tick();  // E2: set and clear together
        get_out(0, d, pe, se, emp, ful, ovr, cnt, dc);
        check("clr.set_wins", int'(ovr), 1);
        tick();  // E3: clear alone
        set_clr(0, 1'b0);
        get_out(0, d, pe, se, emp, ful, ovr, cnt, dc);
        check("clr.cleared", int'(ovr), 0);
        check("clr.count", cnt, 16);
        set_rx(0, 1'b0, 8'hEE, 1'b0, 1'b0);
        repeat (3) tick();

        // ---- Full FIFO, pop in the exact cap cycle of frame 0x55 ----
        set_rx(0, 1'b1, 8'h55, 1'b0, 1'b0);
        tick();  // E0
        tick();  // E1
        set_rd(0, 1'b1);
        tick();  // E2: push and pop together
        set_rd(0, 1'b0);
        get_out(0, d, pe, se, emp, ful, ovr, cnt, dc);
        check("popcap.overrun", int'(ovr), 0);
        check("popcap.count", cnt, 16);
        check("popcap.full", int'(ful), 1);
        tick();
        set_rx(0, 1'b0, 8'h55, 1'b0, 1'b0);
        repeat (3) tick();
        for (int i = 1; i < 16; i++) begin
            check_head(0, $sformatf("drain%0d", i), 8'(i), 17 - i);
            read1(0);
        end
        check_head(0, "drain_last", 8'h55, 1);
        read1(0);
        get_out(0, d, pe, se, emp, ful, ovr, cnt, dc);
        check("drain.empty", int'(emp), 1);
        check("drain.count", cnt, 0);

        // ---- Asynchronous reset during a read with 5 entries queued ----
        for (int i = 0; i < 7; i++) send_frame(0, 8'h61 + 8'(i), 1'b0, 1'b0);
        read1(0);
        read1(0);
        check_head(0, "prerst", 8'h63, 5);
        set_rd(0, 1'b1);
        #2 rst0 = 1'b1;
        #1;
        get_out(0, d, pe, se, emp, ful, ovr, cnt, dc);
        check("arst.count", cnt, 0);
        check("arst.empty", int'(emp), 1);
        tick();
        rst0 = 1'b0;
        set_rd(0, 1'b0);
        tick();
        send_frame(0, 8'h3C, 1'b0, 1'b0);
        check_head(0, "postrst", 8'h3C, 1);
        get_out(0, d, pe, se, emp, ful, ovr, cnt, dc);
        check("postrst.perr", int'(pe), 0);
        check("postrst.serr", int'(se), 0);

        // ---- Drop mode: table of frames and reads on dut1 ----
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].is_read) read1(1);
            else send_frame(1, vecs[i].data, vecs[i].pe, vecs[i].se);
            get_out(1, d, pe, se, emp, ful, ovr, cnt, dc);
            check($sformatf("vec%0d.count", i), cnt, vecs[i].exp_count);
            check($sformatf("vec%0d.drop", i), dc, vecs[i].exp_drop);
            check($sformatf("vec%0d.empty", i), int'(emp), int'(vecs[i].exp_count == 0));
            if (vecs[i].exp_count > 0) begin
                check($sformatf("vec%0d.head", i), int'(d), int'(vecs[i].exp_head));
                check($sformatf("vec%0d.herr", i), int'({se, pe}), 0);
            end
        end

        // ---- Saturation of err_drop_cnt ----
        for (int i = 0; i < 300; i++) begin
            int k;
            k = $urandom_range(1, 3);
            send_frame(1, 8'($urandom), k[0], k[1]);
        end
        get_out(1, d, pe, se, emp, ful, ovr, cnt, dc);
        check("sat.drop_cnt", dc, 255);
        check("sat.count", cnt, 0);

        // ---- Randomized traffic against the frame-level model ----
        rst0 = 1'b1; rst1 = 1'b1;
        tick();
        rst0 = 1'b0; rst1 = 1'b0;
        tick();
        mq0.delete(); mq1.delete();
        mov[0] = 0; mov[1] = 0; mdrop[0] = 0; mdrop[1] = 0;
        for (int n = 0; n < 300; n++) begin
            int sel, op;
            logic [7:0] rd;
            logic rpe, rse;
            sel = int'($urandom_range(0, 1));
            op  = int'($urandom_range(0, 9));
            if (op <= 5) begin
                rd  = 8'($urandom);
                rpe = ($urandom_range(0, 3) == 0);
                rse = ($urandom_range(0, 3) == 0);
                send_frame(sel, rd, rpe, rse);
                model_frame(sel, rd, rpe, rse);
            end else if (op <= 8) begin
                read1(sel);
                model_pop(sel);
            end else begin
                set_clr(sel, 1'b1);
                tick();
                set_clr(sel, 1'b0);
                mov[sel] = 0;
            end
            check_model(sel, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
